// File: rtl/sram_burst_tester_if.sv
// Bus bundle between the SRAM burst tester and its surroundings:
// control/status towards the display logic and the raw SRAM pin signals.
interface sram_burst_tester_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] seed;
  logic [LEN_W-1:0]  len;
  logic [1:0]        mode;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] ram_din;
  logic              ram_drive;
  logic              ram_we_n;
  logic              ram_oe_n;
  logic              ram_en_n;

  logic              busy;
  logic              done;
  logic              pass;
  logic [LEN_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] last_rd;

  // The tester itself: drives the SRAM pins and the status outputs.
  modport master (
    input  start, base_addr, seed, len, mode, ram_din,
    output ram_addr, ram_dout, ram_drive, ram_we_n, ram_oe_n, ram_en_n,
    output busy, done, pass, err_count, first_err_addr, last_rd
  );

  // The requester / pad / SRAM side.
  modport slave (
    output start, base_addr, seed, len, mode, ram_din,
    input  ram_addr, ram_dout, ram_drive, ram_we_n, ram_oe_n, ram_en_n,
    input  busy, done, pass, err_count, first_err_addr, last_rd
  );
endinterface

// File: rtl/sram_burst_tester.sv
// SRAM write/read-back sequencer: writes a burst of pattern words starting
// at a base address, reads them back, and reports pass/fail, mismatch count,
// first failing address and the last word read. All pin outputs are
// registered so the SRAM sees glitch-free strobes.
module sram_burst_tester #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int ACC_CYC = 2
) (
  input logic CLK,
  input logic RST,
  sram_burst_tester_if.master bus
);

  localparam int ACC_W = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE, W_SET, W_PUL, W_HLD, R_SET, R_PUL, R_CMP, FIN
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  idx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base_r;
  logic [DATA_W-1:0] seed_r;
  logic [LEN_W-1:0]  len_r;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] sample;
  logic              first_seen;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;
  logic              ram_drive;
  logic              ram_we_n;
  logic              ram_oe_n;
  logic              ram_en_n;
  logic              busy;
  logic              done;
  logic              pass;
  logic [LEN_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] last_rd;

  logic [DATA_W-1:0] expected;
  logic              mismatch;
  logic              last_word;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  idx_next;

  // Pattern word i at address a; the same function generates write data and
  // the read-back reference, so both phases always agree on the pattern.
  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] s,
    input logic [LEN_W-1:0]  i,
    input logic [DATA_W-1:0] a_lo
  );
    case (m)
      2'd0:    pattern = s + DATA_W'(i);
      2'd1:    pattern = s;
      2'd2:    pattern = s ^ a_lo;
      default: pattern = i[0] ? ~s : s;
    endcase
  endfunction

  assign addr_next = addr + ADDR_W'(1);
  assign idx_next  = idx + LEN_W'(1);
  assign last_word = (idx == len_r - LEN_W'(1));
  assign expected  = pattern(mode_r, seed_r, idx, addr[DATA_W-1:0]);
  assign mismatch  = (sample != expected);

  assign bus.ram_addr       = ram_addr;
  assign bus.ram_dout       = ram_dout;
  assign bus.ram_drive      = ram_drive;
  assign bus.ram_we_n       = ram_we_n;
  assign bus.ram_oe_n       = ram_oe_n;
  assign bus.ram_en_n       = ram_en_n;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.first_err_addr = first_err_addr;
  assign bus.last_rd        = last_rd;

  // Burst sequencer; outputs for each state are loaded on the edge entering it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      acc            <= '0;
      idx            <= '0;
      addr           <= '0;
      base_r         <= '0;
      seed_r         <= '0;
      len_r          <= '0;
      mode_r         <= '0;
      sample         <= '0;
      first_seen     <= 1'b0;
      ram_addr       <= '0;
      ram_dout       <= '0;
      ram_drive      <= 1'b0;
      ram_we_n       <= 1'b1;
      ram_oe_n       <= 1'b1;
      ram_en_n       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      last_rd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            err_count      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
            if (bus.len != '0) begin
              base_r    <= bus.base_addr;
              seed_r    <= bus.seed;
              len_r     <= bus.len;
              mode_r    <= bus.mode;
              idx       <= '0;
              addr      <= bus.base_addr;
              busy      <= 1'b1;
              ram_en_n  <= 1'b0;
              ram_drive <= 1'b1;
              ram_addr  <= bus.base_addr;
              ram_dout  <= pattern(bus.mode, bus.seed, '0, bus.base_addr[DATA_W-1:0]);
              state     <= W_SET;
            end else begin
              state <= FIN;
            end
          end
        end
        W_SET: begin
          ram_we_n <= 1'b0;
          acc      <= '0;
          state    <= W_PUL;
        end
        W_PUL: begin
          if (acc == ACC_W'(ACC_CYC - 1)) begin
            ram_we_n <= 1'b1;
            state    <= W_HLD;
          end else begin
            acc <= acc + ACC_W'(1);
          end
        end
        W_HLD: begin
          if (last_word) begin
            idx       <= '0;
            addr      <= base_r;
            ram_addr  <= base_r;
            ram_drive <= 1'b0;
            state     <= R_SET;
          end else begin
            idx      <= idx_next;
            addr     <= addr_next;
            ram_addr <= addr_next;
            ram_dout <= pattern(mode_r, seed_r, idx_next, addr_next[DATA_W-1:0]);
            state    <= W_SET;
          end
        end
        R_SET: begin
          ram_oe_n <= 1'b0;
          acc      <= '0;
          state    <= R_PUL;
        end
        R_PUL: begin
          if (acc == ACC_W'(ACC_CYC - 1)) begin
            sample   <= bus.ram_din;
            ram_oe_n <= 1'b1;
            state    <= R_CMP;
          end else begin
            acc <= acc + ACC_W'(1);
          end
        end
        R_CMP: begin
          last_rd <= sample;
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + LEN_W'(1);
            if (!first_seen) begin
              first_seen     <= 1'b1;
              first_err_addr <= addr;
            end
          end
          if (last_word) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            pass     <= (err_count == '0) && !mismatch;
            ram_en_n <= 1'b1;
            state    <= FIN;
          end else begin
            idx      <= idx_next;
            addr     <= addr_next;
            ram_addr <= addr_next;
            state    <= R_SET;
          end
        end
        FIN: begin
          // A normal burst enters FIN with done already raised; a zero-length
          // request enters with done low and raises it on the way out.
          if (done) begin
            done <= 1'b0;
          end else begin
            done <= 1'b1;
            pass <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_tester.sv
// Self-checking bench for sram_burst_tester: a behavioural SRAM with
// optional read corruption, a table of burst vectors, and hand sequences
// for zero-length, ignored restart and mid-access reset.
module tb_sram_burst_tester;

  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 8;
  localparam int ACC_CYC = 2;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   oe_cnt = 0;
  int   overlap_cnt = 0;

  // 0 = clean reads, 1 = one address reads with bit 0 stuck high, 2 = every read has bit 0 flipped
  int                corrupt = 0;
  logic [ADDR_W-1:0] stuck_addr = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_word;

  sram_burst_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sram_burst_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ACC_CYC(ACC_CYC)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to measure start-to-done latency.
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM write port: latch data on every cycle of an active write strobe.
  always @(posedge clk) begin
    if (!bus.ram_en_n && !bus.ram_we_n && bus.ram_drive) mem[bus.ram_addr] <= bus.ram_dout;
  end

  // SRAM read port, with the selected fault injected on the returned word.
  always_comb begin
    rd_word = mem[bus.ram_addr];
    if (corrupt == 1 && bus.ram_addr == stuck_addr) rd_word[0] = 1'b1;
    if (corrupt == 2) rd_word[0] = ~rd_word[0];
    if (bus.ram_oe_n || bus.ram_en_n) rd_word = '0;
  end
  assign bus.ram_din = rd_word;

  // Strobe activity counters; bursts are judged on their before/after difference.
  always @(posedge clk) begin
    if (!bus.ram_we_n) we_cnt <= we_cnt + 1;
    if (!bus.ram_oe_n) oe_cnt <= oe_cnt + 1;
  end

  // Bus contention watch: the pad must never drive while the SRAM drives.
  always @(negedge clk) begin
    if (bus.ram_drive && !bus.ram_oe_n) overlap_cnt <= overlap_cnt + 1;
  end

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] seed;
    logic [LEN_W-1:0]  len;
    logic [1:0]        mode;
    int                corrupt;
    logic [ADDR_W-1:0] stuck;
    int                cycles;
    logic              pass;
    logic [LEN_W-1:0]  err;
    logic [ADDR_W-1:0] first;
    logic [DATA_W-1:0] last;
    logic [DATA_W-1:0] word0;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic apply_stimulus(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] seed,
                                input logic [LEN_W-1:0] len, input logic [1:0] mode, output int t0);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.seed      = seed;
    bus.len       = len;
    bus.mode      = mode;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = ~base;
    bus.seed      = ~seed;
    bus.len       = 8'd1;
    bus.mode      = ~mode;
  endtask

  task automatic wait_done(input int t0, output int cycles);
    int n = 0;
    while (bus.done !== 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    cycles = cyc - t0;
    check_output("done_seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int t0, cycles, we0, oe0, n;
    logic [DATA_W-1:0] wr_seen;

    vecs[0] = '{18'h00010, 16'h0005, 8'd10,  2'd0, 0, 18'h0,     81, 1'b1, 8'd0,   18'h0,     16'h000E, 16'h0005};
    vecs[1] = '{18'h00010, 16'h0005, 8'd10,  2'd0, 1, 18'h00013, 81, 1'b0, 8'd1,   18'h00013, 16'h000E, 16'h0005};
    vecs[2] = '{18'h3FFFE, 16'hFFFF, 8'd4,   2'd2, 0, 18'h0,     33, 1'b1, 8'd0,   18'h0,     16'hFFFE, 16'h0001};
    vecs[3] = '{18'h00020, 16'h00F0, 8'd2,   2'd3, 0, 18'h0,     17, 1'b1, 8'd0,   18'h0,     16'hFF0F, 16'h00F0};
    vecs[4] = '{18'h00040, 16'hA5A5, 8'd5,   2'd1, 0, 18'h0,     41, 1'b1, 8'd0,   18'h0,     16'hA5A5, 16'hA5A5};
    vecs[5] = '{18'h00030, 16'hFFFE, 8'd3,   2'd0, 0, 18'h0,     25, 1'b1, 8'd0,   18'h0,     16'h0000, 16'hFFFE};
    vecs[6] = '{18'h00100, 16'h1234, 8'd255, 2'd1, 2, 18'h0,   2041, 1'b0, 8'd255, 18'h00100, 16'h1235, 16'h1234};

    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.seed      = '0;
    bus.len       = '0;
    bus.mode      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_busy",      32'(bus.busy),      32'd0);
    check_output("reset_done",      32'(bus.done),      32'd0);
    check_output("reset_pass",      32'(bus.pass),      32'd0);
    check_output("reset_err",       32'(bus.err_count), 32'd0);
    check_output("reset_we_n",      32'(bus.ram_we_n),  32'd1);
    check_output("reset_oe_n",      32'(bus.ram_oe_n),  32'd1);
    check_output("reset_en_n",      32'(bus.ram_en_n),  32'd1);
    check_output("reset_drive",     32'(bus.ram_drive), 32'd0);
    check_output("reset_addr",      32'(bus.ram_addr),  32'd0);
    check_output("reset_last_rd",   32'(bus.last_rd),   32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table-driven bursts");
    for (int v = 0; v < 7; v++) begin
      corrupt    = vecs[v].corrupt;
      stuck_addr = vecs[v].stuck;
      we0 = we_cnt;
      oe0 = oe_cnt;
      apply_stimulus(vecs[v].base, vecs[v].seed, vecs[v].len, vecs[v].mode, t0);
      check_output($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd1);
      wait_done(t0, cycles);
      check_output($sformatf("v%0d_cycles", v), 32'(cycles),            32'(vecs[v].cycles));
      check_output($sformatf("v%0d_pass", v),   32'(bus.pass),          32'(vecs[v].pass));
      check_output($sformatf("v%0d_err", v),    32'(bus.err_count),     32'(vecs[v].err));
      check_output($sformatf("v%0d_first", v),  32'(bus.first_err_addr), 32'(vecs[v].first));
      check_output($sformatf("v%0d_last", v),   32'(bus.last_rd),       32'(vecs[v].last));
      check_output($sformatf("v%0d_busy_end", v), 32'(bus.busy),        32'd0);
      check_output($sformatf("v%0d_word0", v),  32'(mem[vecs[v].base]), 32'(vecs[v].word0));
      @(posedge clk);
      #1;
      check_output($sformatf("v%0d_done_pulse", v), 32'(bus.done), 32'd0);
      check_output($sformatf("v%0d_we_cycles", v), 32'(we_cnt - we0), 32'(int'(vecs[v].len) * ACC_CYC));
      check_output($sformatf("v%0d_oe_cycles", v), 32'(oe_cnt - oe0), 32'(int'(vecs[v].len) * ACC_CYC));
      corrupt = 0;
    end

    $display("[TB] burst 0 data image");
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("mem_%0h", 16 + i), 32'(mem[18'h10 + 18'(i)]), 32'(16'h0005 + 16'(i)));
    end
    check_output("wrap_mem_3ffff", 32'(mem[18'h3FFFF]), 32'h0000);
    check_output("wrap_mem_00000", 32'(mem[18'h00000]), 32'hFFFF);
    check_output("wrap_mem_00001", 32'(mem[18'h00001]), 32'hFFFE);
    check_output("mode3_mem_21",   32'(mem[18'h00021]), 32'hFF0F);

    $display("[TB] zero-length request");
    we0 = we_cnt;
    oe0 = oe_cnt;
    apply_stimulus(18'h00200, 16'h1111, 8'd0, 2'd0, t0);
    check_output("len0_busy", 32'(bus.busy), 32'd0);
    wait_done(t0, cycles);
    check_output("len0_cycles", 32'(cycles),        32'd2);
    check_output("len0_pass",   32'(bus.pass),      32'd1);
    check_output("len0_err",    32'(bus.err_count), 32'd0);
    check_output("len0_first",  32'(bus.first_err_addr), 32'd0);
    @(posedge clk);
    #1;
    check_output("len0_done_pulse", 32'(bus.done), 32'd0);
    check_output("len0_we",     32'(we_cnt - we0),  32'd0);
    check_output("len0_oe",     32'(oe_cnt - oe0),  32'd0);

    $display("[TB] restart while busy");
    we0 = we_cnt;
    apply_stimulus(18'h00050, 16'h0100, 8'd4, 2'd0, t0);
    repeat (4) @(posedge clk);
    begin
      int t_ign;
      apply_stimulus(18'h00060, 16'h7777, 8'd1, 2'd1, t_ign);
    end
    wait_done(t0, cycles);
    check_output("restart_cycles", 32'(cycles),        32'd33);
    check_output("restart_pass",   32'(bus.pass),      32'd1);
    check_output("restart_last",   32'(bus.last_rd),   32'h0103);
    check_output("restart_mem53",  32'(mem[18'h53]),   32'h0103);
    @(posedge clk);
    #1;
    check_output("restart_we",     32'(we_cnt - we0),  32'd8);

    $display("[TB] reset during write pulse");
    apply_stimulus(18'h00070, 16'h0AAA, 8'd4, 2'd0, t0);
    n = 0;
    while (bus.ram_we_n !== 1'b0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("rst_we_low_seen", 32'(bus.ram_we_n), 32'd0);
    wr_seen = bus.ram_dout;
    check_output("rst_wr_data", 32'(wr_seen), 32'h0AAA);
    rst = 1'b0;
    #1;
    check_output("rst_we_n",  32'(bus.ram_we_n),  32'd1);
    check_output("rst_en_n",  32'(bus.ram_en_n),  32'd1);
    check_output("rst_drive", 32'(bus.ram_drive), 32'd0);
    check_output("rst_busy",  32'(bus.busy),      32'd0);
    check_output("rst_pass",  32'(bus.pass),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(18'h00080, 16'h0042, 8'd3, 2'd0, t0);
    wait_done(t0, cycles);
    check_output("post_rst_cycles", 32'(cycles),      32'd25);
    check_output("post_rst_pass",   32'(bus.pass),    32'd1);
    check_output("post_rst_last",   32'(bus.last_rd), 32'h0044);
    @(posedge clk);
    #1;

    check_output("drive_oe_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
